// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store over valid/ready, a
// configurable wait before the RAM access, and a registered response.
// Optional feature macro: DMEM_MISALIGN_CHECK_EN flags accesses with
// req_addr[1:0] != 0 as errors (no write, zero read data).
module dmem_responder #(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_we,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  // Wait counter start value; unused when there is no wait phase.
  localparam logic [3:0] LatCnt = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StAccess, StResp} stateT;

  stateT           stateQ, stateD;
  logic [3:0]      cntQ, cntD;
  logic [IdxW-1:0] idxQ;
  logic [31:0]     wdataQ;
  logic            weQ;
  logic            misQ;
  logic            misReq;
  logic [31:0]     rdataQ;
  logic            errQ;
  logic            accept;
  logic            unusedAddr;

  logic [31:0]     mem [DEPTH];

  assign accept = req_valid && (stateQ == StIdle);

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misReq     = |req_addr[1:0];
  assign unusedAddr = ^req_addr[31:IdxW+2];
`else
  assign misReq     = 1'b0;
  assign unusedAddr = ^{req_addr[31:IdxW+2], req_addr[1:0]};
`endif

  // State and wait-counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= StIdle;
      cntQ   <= 4'd0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
    end
  end

  // Next-state logic
  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    unique case (stateQ)
      StIdle: begin
        if (accept) begin
          if (LATENCY > 0) begin
            stateD = StWait;
            cntD   = LatCnt;
          end else begin
            stateD = StAccess;
          end
        end
      end
      StWait: begin
        if (cntQ == 4'd0) stateD = StAccess;
        else              cntD   = cntQ - 4'd1;
      end
      StAccess: stateD = StResp;
      StResp:   if (rsp_ready) stateD = StIdle;
      default:  stateD = StIdle;
    endcase
  end

  // Capture the request on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idxQ   <= '0;
      wdataQ <= 32'd0;
      weQ    <= 1'b0;
      misQ   <= 1'b0;
    end else if (accept) begin
      idxQ   <= req_addr[IdxW+1:2];
      wdataQ <= req_wdata;
      weQ    <= req_we;
      misQ   <= misReq;
    end
  end

  // RAM write port; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (stateQ == StAccess && weQ && !misQ) mem[idxQ] <= wdataQ;
  end

  // Response registers, loaded in ACCESS and held through RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdataQ <= 32'd0;
      errQ   <= 1'b0;
    end else if (stateQ == StAccess) begin
      rdataQ <= (weQ || misQ) ? 32'd0 : mem[idxQ];
      errQ   <= misQ;
    end
  end

  // Outputs decoded from state or taken straight from registers
  always_comb begin
    req_ready = (stateQ == StIdle);
    rsp_valid = (stateQ == StResp);
    rsp_rdata = rdataQ;
    rsp_err   = errQ;
  end

endmodule
